// File: rtl/mem_seq_master.sv
// Bus-master sequencer for the 256x8 scratch memory: runs one fill, copy or
// compare command over a contiguous, wrapping byte range per start pulse.
module mem_seq_master #(
    parameter int AW = 8,
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [1:0]    op,
    input  logic [AW-1:0] src,
    input  logic [AW-1:0] dst,
    input  logic [AW-1:0] len,
    input  logic [DW-1:0] pattern,
    output logic          busy,
    output logic          done,
    output logic          mismatch,
    output logic [AW-1:0] mismatch_addr,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_din,
    output logic          mem_we,
    input  logic [DW-1:0] mem_dout
);

    typedef enum logic [2:0] {
        IDLE,
        FILL,
        CPY_RD,
        CPY_WR,
        CMP,
        DONE
    } state_e;

    localparam logic [AW-1:0] ONE = {{(AW-1){1'b0}}, 1'b1};

    state_e        state_q, state_d;
    logic [AW-1:0] idx_q, idx_d;
    logic [AW-1:0] src_q, src_d;
    logic [AW-1:0] dst_q, dst_d;
    logic [AW-1:0] len_q, len_d;
    logic [DW-1:0] pattern_q, pattern_d;
    logic [DW-1:0] data_q, data_d;
    logic          mismatch_q, mismatch_d;
    logic [AW-1:0] mismatch_addr_q, mismatch_addr_d;
    logic          last_byte;

    assign last_byte = (idx_q == (len_q - ONE));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q         <= IDLE;
            idx_q           <= '0;
            src_q           <= '0;
            dst_q           <= '0;
            len_q           <= '0;
            pattern_q       <= '0;
            data_q          <= '0;
            mismatch_q      <= 1'b0;
            mismatch_addr_q <= '0;
        end else begin
            state_q         <= state_d;
            idx_q           <= idx_d;
            src_q           <= src_d;
            dst_q           <= dst_d;
            len_q           <= len_d;
            pattern_q       <= pattern_d;
            data_q          <= data_d;
            mismatch_q      <= mismatch_d;
            mismatch_addr_q <= mismatch_addr_d;
        end
    end

    // The command is captured on acceptance so later input changes cannot disturb it.
    always_comb begin
        state_d         = state_q;
        idx_d           = idx_q;
        src_d           = src_q;
        dst_d           = dst_q;
        len_d           = len_q;
        pattern_d       = pattern_q;
        data_d          = data_q;
        mismatch_d      = mismatch_q;
        mismatch_addr_d = mismatch_addr_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    src_d           = src;
                    dst_d           = dst;
                    len_d           = len;
                    pattern_d       = pattern;
                    idx_d           = '0;
                    mismatch_d      = 1'b0;
                    mismatch_addr_d = '0;
                    if (len == '0 || op == 2'b11) begin
                        state_d = DONE;
                    end else if (op == 2'b00) begin
                        state_d = FILL;
                    end else if (op == 2'b01) begin
                        state_d = CPY_RD;
                    end else begin
                        state_d = CMP;
                    end
                end
            end
            FILL: begin
                idx_d = idx_q + ONE;
                if (last_byte) state_d = DONE;
            end
            CPY_RD: begin
                data_d  = mem_dout;
                state_d = CPY_WR;
            end
            CPY_WR: begin
                idx_d   = idx_q + ONE;
                state_d = last_byte ? DONE : CPY_RD;
            end
            CMP: begin
                if (mem_dout != pattern_q) begin
                    mismatch_d      = 1'b1;
                    mismatch_addr_d = dst_q + idx_q;
                    state_d         = DONE;
                end else begin
                    idx_d = idx_q + ONE;
                    if (last_byte) state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy     = (state_q != IDLE);
        done     = (state_q == DONE);
        mem_addr = '0;
        mem_din  = '0;
        mem_we   = 1'b0;
        unique case (state_q)
            FILL: begin
                mem_addr = dst_q + idx_q;
                mem_din  = pattern_q;
                mem_we   = 1'b1;
            end
            CPY_RD: mem_addr = src_q + idx_q;
            CPY_WR: begin
                mem_addr = dst_q + idx_q;
                mem_din  = data_q;
                mem_we   = 1'b1;
            end
            CMP:     mem_addr = dst_q + idx_q;
            default: ;
        endcase
    end

    assign mismatch      = mismatch_q;
    assign mismatch_addr = mismatch_addr_q;

endmodule

// File: tb/tb_mem_seq_master.sv
// Directed bench for mem_seq_master with a behavioural 256x8 scratch memory
// attached; expected values are hand-derived from the command timing.
module tb_mem_seq_master;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [1:0] op;
    logic [7:0] src, dst, len, pattern;
    logic       busy, done, mismatch;
    logic [7:0] mismatch_addr, mem_addr, mem_din, mem_dout;
    logic       mem_we;

    logic [7:0] mem [256];
    logic [8:0] trace [$];
    int checks = 0;
    int errors = 0;
    int doneAt, weCnt;

    mem_seq_master #(.AW(8), .DW(8)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op), .src(src), .dst(dst),
        .len(len), .pattern(pattern), .busy(busy), .done(done), .mismatch(mismatch),
        .mismatch_addr(mismatch_addr), .mem_addr(mem_addr), .mem_din(mem_din),
        .mem_we(mem_we), .mem_dout(mem_dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) if (mem_we) mem[mem_addr] <= mem_din;
    assign mem_dout = mem[mem_addr];

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Called at a negedge while idle; returns at the negedge of the first idle cycle after DONE.
    task automatic applyStimulus(input logic [1:0] o, input logic [7:0] s, input logic [7:0] d,
                                 input logic [7:0] l, input logic [7:0] p, input int glitchCycle,
                                 output int doneCycle, output int weCount);
        int cyc;
        op = o; src = s; dst = d; len = l; pattern = p; start = 1'b1;
        @(negedge clk);
        cyc = 1; doneCycle = -1; weCount = 0; trace.delete();
        while (doneCycle < 0 && cyc <= 600) begin
            start = (cyc == glitchCycle);
            if (cyc == glitchCycle) begin
                op = ~o; src = s + 8'd1; dst = d + 8'd160; len = 8'd3; pattern = ~p;
            end
            if (mem_we) weCount++;
            if (done) doneCycle = cyc;
            else begin
                trace.push_back({mem_we, mem_addr});
                @(negedge clk);
                cyc++;
            end
        end
        start = 1'b0;
        @(negedge clk);
        checkOutput("busyFall", {31'd0, busy}, 32'd0);
    endtask

    initial begin
        logic [7:0] a;
        rst_n = 1'b0; start = 1'b0; op = 2'b00; src = '0; dst = '0; len = '0; pattern = '0;
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        repeat (2) @(negedge clk);
        checkOutput("rstBusy", {31'd0, busy}, 32'd0);
        checkOutput("rstDone", {31'd0, done}, 32'd0);
        checkOutput("rstMismatch", {31'd0, mismatch}, 32'd0);
        checkOutput("rstMismatchAddr", {24'd0, mismatch_addr}, 32'd0);
        checkOutput("rstMemWe", {31'd0, mem_we}, 32'd0);
        checkOutput("rstMemAddr", {24'd0, mem_addr}, 32'd0);
        checkOutput("rstMemDin", {24'd0, mem_din}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        $display("[TB] fill 20..31 with 5A");
        applyStimulus(2'b00, 8'd0, 8'd20, 8'd12, 8'h5A, 0, doneAt, weCnt);
        checkOutput("fillDone", doneAt, 32'd13);
        checkOutput("fillWeCount", weCnt, 32'd12);
        for (int i = 20; i < 32; i++) checkOutput("fillData", {24'd0, mem[i]}, 32'h5A);
        checkOutput("fillBelow", {24'd0, mem[19]}, 32'd0);
        checkOutput("fillAbove", {24'd0, mem[32]}, 32'd0);

        $display("[TB] copy 20..23 to 100..103");
        applyStimulus(2'b01, 8'd20, 8'd100, 8'd4, 8'h00, 0, doneAt, weCnt);
        checkOutput("copyDone", doneAt, 32'd9);
        checkOutput("copyTraceLen", trace.size(), 32'd8);
        for (int j = 0; j < 8 && j < trace.size(); j++) begin
            a = (j % 2 == 0) ? 8'd20 + 8'(j / 2) : 8'd100 + 8'(j / 2);
            checkOutput("copyTrace", {23'd0, trace[j]}, {23'd0, (j % 2 == 1), a});
        end
        for (int i = 100; i < 104; i++) checkOutput("copyData", {24'd0, mem[i]}, 32'h5A);
        checkOutput("copyPast", {24'd0, mem[104]}, 32'd0);

        $display("[TB] compare clean");
        applyStimulus(2'b10, 8'd0, 8'd20, 8'd12, 8'h5A, 0, doneAt, weCnt);
        checkOutput("cmpDone", doneAt, 32'd13);
        checkOutput("cmpMismatch", {31'd0, mismatch}, 32'd0);
        checkOutput("cmpWe", weCnt, 32'd0);

        $display("[TB] poke 25 and compare again");
        applyStimulus(2'b00, 8'd0, 8'd25, 8'd1, 8'h00, 0, doneAt, weCnt);
        checkOutput("pokeDone", doneAt, 32'd2);
        applyStimulus(2'b10, 8'd0, 8'd20, 8'd12, 8'h5A, 0, doneAt, weCnt);
        checkOutput("cmpBadDone", doneAt, 32'd7);
        checkOutput("cmpBadFlag", {31'd0, mismatch}, 32'd1);
        checkOutput("cmpBadAddr", {24'd0, mismatch_addr}, 32'd25);

        $display("[TB] wrapping fill");
        applyStimulus(2'b00, 8'd0, 8'hFE, 8'd4, 8'h11, 0, doneAt, weCnt);
        checkOutput("wrapDone", doneAt, 32'd5);
        checkOutput("wrapMismatchCleared", {31'd0, mismatch}, 32'd0);
        checkOutput("wrapTraceLen", trace.size(), 32'd4);
        for (int j = 0; j < 4 && j < trace.size(); j++) begin
            a = 8'hFE + 8'(j);
            checkOutput("wrapAddr", {23'd0, trace[j]}, {23'd0, 1'b1, a});
        end
        checkOutput("wrapData0", {24'd0, mem[0]}, 32'h11);
        checkOutput("wrapData2", {24'd0, mem[2]}, 32'h00);

        $display("[TB] degenerate commands");
        applyStimulus(2'b00, 8'd0, 8'd60, 8'd0, 8'hEE, 0, doneAt, weCnt);
        checkOutput("len0Done", doneAt, 32'd1);
        checkOutput("len0We", weCnt, 32'd0);
        applyStimulus(2'b11, 8'd0, 8'd60, 8'd5, 8'hEE, 0, doneAt, weCnt);
        checkOutput("op3Done", doneAt, 32'd1);
        checkOutput("op3We", weCnt, 32'd0);
        checkOutput("op3Mem", {24'd0, mem[60]}, 32'd0);

        $display("[TB] start pulsed while busy");
        applyStimulus(2'b00, 8'd0, 8'd40, 8'd6, 8'h77, 3, doneAt, weCnt);
        checkOutput("glitchDone", doneAt, 32'd7);
        checkOutput("glitchWe", weCnt, 32'd6);
        checkOutput("glitchFirst", {24'd0, mem[40]}, 32'h77);
        checkOutput("glitchLast", {24'd0, mem[45]}, 32'h77);
        checkOutput("glitchOther", {24'd0, mem[200]}, 32'd0);

        $display("[TB] reset mid-copy");
        op = 2'b01; src = 8'd20; dst = 8'd150; len = 8'd8; pattern = 8'h00; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        checkOutput("preRstBusy", {31'd0, busy}, 32'd1);
        rst_n = 1'b0;
        @(negedge clk);
        checkOutput("midRstBusy", {31'd0, busy}, 32'd0);
        checkOutput("midRstWe", {31'd0, mem_we}, 32'd0);
        checkOutput("midRstDone", {31'd0, done}, 32'd0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("postRstIdle", {31'd0, busy}, 32'd0);
        checkOutput("rstByte0", {24'd0, mem[150]}, 32'h5A);
        checkOutput("rstByte1", {24'd0, mem[151]}, 32'h5A);
        checkOutput("rstByte2", {24'd0, mem[152]}, 32'd0);
        checkOutput("rstByte7", {24'd0, mem[157]}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
